mc_ctrl_fsm: RTL and testbench

//  Multicycle main control unit; directly upstream of the processor datapath.
//  - Consumes the datapath's 6-bit opcode.
//  - Sequences FETCH/DECODE/EXECUTE/MEM/WB as a Moore FSM.
//  - Drives every datapath control strobe and mux select.
//  - Also provides a halt-on-illegal-opcode flag and a retired-instruction counter.

---
 rtl/mc_pkg.sv | 86 ++++++++
 rtl/mc_ctrl_decode.sv | 78 +++++++
 rtl/mc_ctrl_fsm.sv | 97 +++++++++
 tb/tb_mc_ctrl_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle main control unit: opcodes, state
// encodings, mux-select encodings and the packed control vector.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_HALT     = 4'd13
    } state_e;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] WDST_RT      = 2'b00;
    localparam logic [1:0] WDST_RD      = 2'b01;
    localparam logic [1:0] WDST_R31     = 2'b10;

    localparam logic [1:0] WDATA_ALUOUT = 2'b00;
    localparam logic [1:0] WDATA_MDR    = 2'b01;
    localparam logic [1:0] WDATA_PC     = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] wreg_dst;
        logic [1:0] wreg_data_sel;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic       imm_com;
        logic       halted;
    } ctrl_t;

    // DECODE dispatch: the first state of each instruction class.
    function automatic state_e dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                   return S_R_EXEC;
            OP_LW, OP_SW:                               return S_MEM_ADDR;
            OP_BEQ:                                     return S_BRANCH;
            OP_J:                                       return S_JUMP;
            OP_JAL:                                     return S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return S_I_EXEC;
            default:                                    return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control vector table for the multicycle controller.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: default the whole vector first so no path through the case infers a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_data_sel = WDATA_MDR;
                ctrl.wreg_dst      = WDST_RT;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wreg_dst  = WDST_RD;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.imm_com   = 1'b1;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wreg_dst  = WDST_RT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            // r31 captures PC+4 on the same edge the PC takes the jump target.
            S_JAL: begin
                ctrl.pc_write      = 1'b1;
                ctrl.pc_source     = PCSRC_JUMP;
                ctrl.reg_write     = 1'b1;
                ctrl.wreg_dst      = WDST_R31;
                ctrl.wreg_data_sel = WDATA_PC;
            end
            S_HALT:     ctrl.halted = 1'b1;
            default:    ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main control FSM: state register, next-state logic, retired
// instruction counter and reset gating of every control output.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [1:0]       wreg_dst,
    output logic [1:0]       wreg_data_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             alu_src_a,
    output logic             imm_com,
    output logic             halted,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl_raw, ctrl_out;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != S_FETCH && state_d == S_FETCH)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = S_HALT;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = dispatch(opcode);
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_HALT;
            end
            S_MEM_RD:   state_d = S_MEM_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JAL:
                        state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            // HALT and any corrupted encoding park here until reset.
            default:    state_d = S_HALT;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl_raw)
    );

    // Strobes drop the instant rst falls, before the flops even settle.
    always_comb begin
        ctrl_out = '0;
        if (rst)
            ctrl_out = ctrl_raw;
    end

    assign alu_op        = ctrl_out.alu_op;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign pc_source     = ctrl_out.pc_source;
    assign wreg_dst      = ctrl_out.wreg_dst;
    assign wreg_data_sel = ctrl_out.wreg_data_sel;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign i_or_d        = ctrl_out.i_or_d;
    assign reg_write     = ctrl_out.reg_write;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign imm_com       = ctrl_out.imm_com;
    assign halted        = ctrl_out.halted;
    assign state_dbg     = state_q;
    assign instr_cnt     = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm plus a 4-bit-counter instance
// used for the counter wrap sequence.
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4;
    logic [5:0]  opcode, op4;

    logic [1:0]  alu_op, alu_src_b, pc_source, wreg_dst, wreg_data_sel;
    logic        mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write;
    logic        pc_write_cond, alu_src_a, imm_com, halted;
    logic [3:0]  state_dbg;
    logic [31:0] instr_cnt;

    logic [1:0]  alu_op4, alu_src_b4, pc_source4, wreg_dst4, wreg_data_sel4;
    logic        mem_read4, mem_write4, i_or_d4, reg_write4, ir_write4, pc_write4;
    logic        pc_write_cond4, alu_src_a4, imm_com4, halted4;
    logic [3:0]  state_dbg4;
    logic [3:0]  instr_cnt4;

    mc_ctrl_fsm u_dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .wreg_dst(wreg_dst), .wreg_data_sel(wreg_data_sel),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a), .imm_com(imm_com),
        .halted(halted), .state_dbg(state_dbg), .instr_cnt(instr_cnt)
    );

    mc_ctrl_fsm #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .opcode(op4),
        .alu_op(alu_op4), .alu_src_b(alu_src_b4), .pc_source(pc_source4),
        .wreg_dst(wreg_dst4), .wreg_data_sel(wreg_data_sel4),
        .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
        .reg_write(reg_write4), .ir_write(ir_write4), .pc_write(pc_write4),
        .pc_write_cond(pc_write_cond4), .alu_src_a(alu_src_a4), .imm_com(imm_com4),
        .halted(halted4), .state_dbg(state_dbg4), .instr_cnt(instr_cnt4)
    );

    // Observed control vector: {alu_op, src_b, pc_src, wdst, wdata, rd, wr, iord, rw, irw, pcw, pcwc, srca, imm, halted}
    logic [19:0] obs;
    assign obs = {alu_op, alu_src_b, pc_source, wreg_dst, wreg_data_sel,
                  mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write,
                  pc_write_cond, alu_src_a, imm_com, halted};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected strobes per state, written straight from the state table.
    function automatic logic [19:0] exp_out(input logic [3:0] s);
        logic [1:0] aop, srcb, pcs, wd, wds;
        logic rd, wr, iod, rw, irw, pcw, pcwc, srca, imm, hlt;
        {aop, srcb, pcs, wd, wds} = '0;
        {rd, wr, iod, rw, irw, pcw, pcwc, srca, imm, hlt} = '0;
        case (s)
            4'd0:  begin rd = 1; irw = 1; pcw = 1; srcb = 2'b01; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin rd = 1; iod = 1; end
            4'd4:  begin rw = 1; wds = 2'b01; wd = 2'b00; end
            4'd5:  begin wr = 1; iod = 1; end
            4'd6:  begin srca = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; wd = 2'b01; end
            4'd8:  begin srca = 1; srcb = 2'b10; aop = 2'b10; imm = 1; end
            4'd9:  begin rw = 1; wd = 2'b00; end
            4'd10: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd11: begin pcw = 1; pcs = 2'b10; end
            4'd12: begin pcw = 1; pcs = 2'b10; rw = 1; wd = 2'b10; wds = 2'b10; end
            4'd13: hlt = 1;
            default: ;
        endcase
        return {aop, srcb, pcs, wd, wds, rd, wr, iod, rw, irw, pcw, pcwc, srca, imm, hlt};
    endfunction

    typedef struct packed {
        logic [5:0]      op;
        logic [2:0]      n;
        logic [4:0][3:0] seq;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] op, input logic [2:0] n,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
        vec_t v;
        v.op     = op;
        v.n      = n;
        v.seq[0] = 4'd0;
        v.seq[1] = 4'd1;
        v.seq[2] = s2;
        v.seq[3] = s3;
        v.seq[4] = s4;
        return v;
    endfunction

    vec_t tbl [11];
    logic [31:0] exp_cnt;

    initial begin
        tbl[0]  = mk(6'b100011, 3'd5, 4'd2,  4'd3, 4'd4);  // LW
        tbl[1]  = mk(6'b000000, 3'd4, 4'd6,  4'd7, 4'd0);  // R-type
        tbl[2]  = mk(6'b001000, 3'd4, 4'd8,  4'd9, 4'd0);  // ADDI
        tbl[3]  = mk(6'b101011, 3'd4, 4'd2,  4'd5, 4'd0);  // SW
        tbl[4]  = mk(6'b000100, 3'd3, 4'd10, 4'd0, 4'd0);  // BEQ
        tbl[5]  = mk(6'b000010, 3'd3, 4'd11, 4'd0, 4'd0);  // J
        tbl[6]  = mk(6'b000011, 3'd3, 4'd12, 4'd0, 4'd0);  // JAL
        tbl[7]  = mk(6'b001100, 3'd4, 4'd8,  4'd9, 4'd0);  // ANDI
        tbl[8]  = mk(6'b001101, 3'd4, 4'd8,  4'd9, 4'd0);  // ORI
        tbl[9]  = mk(6'b001110, 3'd4, 4'd8,  4'd9, 4'd0);  // XORI
        tbl[10] = mk(6'b001010, 3'd4, 4'd8,  4'd9, 4'd0);  // SLTI

        rst = 1'b0; rst4 = 1'b0; opcode = 6'b0; op4 = 6'b000010;

        // Reset held for three clocks: strobes forced low, FETCH, count zero.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'(obs), 32'h0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        rst = 1'b1;
        #1;
        check("fetch_after_rst", 32'(obs), 32'(exp_out(4'd0)));

        // Instruction table: state walk, strobes every cycle, count after each.
        exp_cnt = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        // Re-align: previous edge left us in DECODE with opcode 0; finish that R-type.
        check("align_state", 32'(state_dbg), 32'd1);
        step(); step(); step();
        exp_cnt = 1;
        check("align_cnt", instr_cnt, exp_cnt);
        for (int i = 0; i < 11; i++) begin
            opcode = tbl[i].op;
            for (int c = 0; c < int'(tbl[i].n); c++) begin
                check($sformatf("v%0d_c%0d_state", i, c), 32'(state_dbg), 32'(tbl[i].seq[c]));
                check($sformatf("v%0d_c%0d_ctrl", i, c), 32'(obs), 32'(exp_out(tbl[i].seq[c])));
                check($sformatf("v%0d_c%0d_cnt", i, c), instr_cnt, exp_cnt);
                step();
            end
            exp_cnt = exp_cnt + 1;
            check($sformatf("v%0d_end_state", i), 32'(state_dbg), 32'd0);
            check($sformatf("v%0d_end_cnt", i), instr_cnt, exp_cnt);
        end

        // Illegal opcode: HALT, no strobes for 20 cycles, count frozen.
        opcode = 6'b111111;
        step();
        check("ill_decode", 32'(state_dbg), 32'd1);
        step();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt_state_%0d", k), 32'(state_dbg), 32'd13);
            check($sformatf("halt_ctrl_%0d", k), 32'(obs), 32'(exp_out(4'd13)));
            check($sformatf("halt_cnt_%0d", k), instr_cnt, exp_cnt);
            step();
        end
        rst = 1'b0;
        #1;
        check("halt_rst_state", 32'(state_dbg), 32'd0);
        check("halt_rst_ctrl", 32'(obs), 32'h0);
        check("halt_rst_cnt", instr_cnt, 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("halt_exit_fetch", 32'(obs), 32'(exp_out(4'd0)));

        // Complete one LW, then start another and pull reset mid-clock in MEM_RD.
        opcode = 6'b100011;
        repeat (5) step();
        check("lw_cnt_before_abort", instr_cnt, 32'd1);
        repeat (3) step();
        check("abort_in_memrd", 32'(state_dbg), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ctrl", 32'(obs), 32'h0);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_cnt", instr_cnt, 32'd0);
        step();
        check("abort_no_regwrite", 32'(reg_write), 32'd0);
        check("abort_hold_state", 32'(state_dbg), 32'd0);

        // Narrow counter: 17 J instructions wrap 0xF -> 0x0 -> 0x1.
        rst4 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            repeat (3) step();
            check($sformatf("wrap_state_%0d", k), 32'(state_dbg4), 32'd0);
            check($sformatf("wrap_cnt_%0d", k), 32'(instr_cnt4), 32'(k % 16));
        end
        check("wrap_not_halted", 32'(halted4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
